// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIVU  = 3'd2,
    OP_MFHI  = 3'd3,
    OP_MFLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_iter_core.sv
// One-bit-per-cycle datapath: right-shift shift-add multiply and restoring divide.
// o_hi/o_lo present the accumulator value that the current step will produce.
module hilo_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_start_div,
  input  logic            i_run,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_opb;
  logic              r_div;
  logic [CNT_W-1:0]  r_cnt;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;

  // Multiply: add multiplicand into the upper half, then shift the whole product right
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_opb[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: upper half is the remainder, lower half shifts dividend out and quotient in
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_opb;
  assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  assign w_acc_next = r_div ? w_div_next : w_mul_next;

  assign o_last = i_run && (r_cnt == CNT_W'(XLEN - 1));
  assign o_hi   = w_acc_next[2*XLEN-1:XLEN];
  assign o_lo   = w_acc_next[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_opb   <= '0;
      r_div   <= 1'b0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_acc   <= i_start_div ? {{XLEN{1'b0}}, i_a} : '0;
      r_mcand <= i_a;
      r_opb   <= i_b;
      r_div   <= i_start_div;
      r_cnt   <= '0;
    end else if (i_run) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (!r_div) begin
        r_opb <= r_opb >> 1;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative MULTU/DIVU and the core stall interlock.
//   state   | meaning
//   ST_IDLE | no operation in flight; MF/MT served, MULTU/DIVU accepted
//   ST_MUL  | shift-add multiply iterating, busy
//   ST_DIV  | restoring divide iterating, busy
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_done;

  op_e             w_op;
  logic            w_busy;
  logic            w_real_op;
  logic            w_accept;
  logic            w_start_div;
  logic            w_last;
  logic [XLEN-1:0] w_core_hi;
  logic [XLEN-1:0] w_core_lo;

  assign w_op        = op_e'(op);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_real_op   = op_valid && (w_op != OP_NOP) && (w_op != OP_RSVD);
  assign w_accept    = op_valid && !w_busy && ((w_op == OP_MULTU) || (w_op == OP_DIVU));
  assign w_start_div = (w_op == OP_DIVU);

  hilo_iter_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_accept),
    .i_start_div (w_start_div),
    .i_run       (w_busy),
    .i_a         (a),
    .i_b         (b),
    .o_last      (w_last),
    .o_hi        (w_core_hi),
    .o_lo        (w_core_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_start_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Completion writes only happen while busy and MT writes only while idle, so they never collide
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_hi <= w_core_hi;
        r_lo <= w_core_lo;
      end else if (op_valid && !w_busy) begin
        if (w_op == OP_MTHI) begin
          r_hi <= a;
        end
        if (w_op == OP_MTLO) begin
          r_lo <= a;
        end
      end
    end
  end

  always_comb begin
    result = '0;
    if (op_valid && (w_op == OP_MFHI)) begin
      result = r_hi;
    end else if (op_valid && (w_op == OP_MFLO)) begin
      result = r_lo;
    end
  end

  assign stall = w_real_op && w_busy;
  assign busy  = w_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed scenarios plus random traffic checked against an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] NOP = 3'd0, MULTU = 3'd1, DIVU = 3'd2, MFHI = 3'd3,
                         MFLO = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  hilo_muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results computed at accept time, released after 32 cycles
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_rem = 0;
  bit          m_done = 0;
  bit          m_init = 0;

  always @(posedge clk) begin
    logic [63:0] prod;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 0; m_init = 1;
    end else if (m_init) begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1;
        end
      end else if (op_valid) begin
        case (op)
          MULTU: begin
            prod  = {32'b0, a} * {32'b0, b};
            m_phi = prod[63:32]; m_plo = prod[31:0]; m_rem = 32;
          end
          DIVU: begin
            if (b == 0) begin
              m_plo = 32'hFFFF_FFFF; m_phi = a;
            end else begin
              m_plo = a / b; m_phi = a % b;
            end
            m_rem = 32;
          end
          MTHI: m_hi = a;
          MTLO: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic        e_busy, e_stall;
    logic [31:0] e_res;
    if (m_init) begin
      e_busy  = (m_rem > 0);
      e_stall = op_valid && (op >= 3'd1) && (op <= 3'd6) && e_busy;
      e_res   = (op_valid && op == MFHI) ? m_hi : (op_valid && op == MFLO) ? m_lo : 32'h0;
      chk("cyc_busy",   {31'b0, busy},  {31'b0, e_busy});
      chk("cyc_stall",  {31'b0, stall}, {31'b0, e_stall});
      chk("cyc_done",   {31'b0, done},  {31'b0, m_done});
      chk("cyc_result", result, e_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    op_valid = v; op = o; a = aa; b = bb;
  endtask

  task automatic rd(input logic [2:0] o, input logic [31:0] exp, input string name);
    drive(1'b1, o, $urandom, $urandom);
    #2;
    chk(name, result, exp);
    chk({name, "_nostall"}, {31'b0, stall}, 32'h0);
    tick();
    drive(1'b0, NOP, '0, '0);
  endtask

  // Issue one MULTU/DIVU, then confirm busy lasts 32 cycles and done coincides with busy falling
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb, input string name);
    int cyc;
    drive(1'b1, o, aa, bb);
    tick();
    drive(1'b0, NOP, $urandom, $urandom);
    cyc = 1;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({name, "_busy_len"}, cyc - 1, 32);
    chk({name, "_done"}, {31'b0, done}, 32'h1);
  endtask

  initial begin
    int n;
    bit seen;

    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    rd(MFHI, 32'h0, "reset_hi");
    rd(MFLO, 32'h0, "reset_lo");

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    rd(MFHI, 32'hFFFF_FFFE, "mul_max_hi");
    rd(MFLO, 32'h0000_0001, "mul_max_lo");

    run_op(DIVU, 32'd100, 32'd7, "div_100_7");
    rd(MFLO, 32'd14, "div_q");
    rd(MFHI, 32'd2, "div_r");

    run_op(DIVU, 32'd5, 32'd0, "div0");
    rd(MFLO, 32'hFFFF_FFFF, "div0_lo");
    rd(MFHI, 32'd5, "div0_hi");

    // MFLO held behind a DIVU
    drive(1'b1, DIVU, 32'd100, 32'd7);
    tick();
    drive(1'b1, MFLO, 32'd0, 32'd0);
    n = 0;
    #2;
    while (stall && n < 100) begin
      n++;
      tick();
      #2;
    end
    chk("mflo_stall_len", n, 32);
    chk("mflo_after_stall", result, 32'd14);
    tick();
    drive(1'b0, NOP, '0, '0);

    // Reset in the 10th busy cycle
    drive(1'b1, DIVU, 32'd1234, 32'd5);
    tick();
    drive(1'b0, NOP, '0, '0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    seen = 0;
    repeat (40) begin
      if (done) seen = 1;
      tick();
    end
    chk("abort_no_done", {31'b0, seen}, 32'h0);
    rd(MFHI, 32'h0, "abort_hi");
    rd(MFLO, 32'h0, "abort_lo");

    drive(1'b1, MTHI, 32'h1234_5678, 32'h0);
    tick();
    drive(1'b1, MTLO, 32'hCAFE_F00D, 32'h0);
    tick();
    rd(MFHI, 32'h1234_5678, "mthi");
    rd(MFLO, 32'hCAFE_F00D, "mtlo");

    run_op(MULTU, 32'd3, 32'd4, "mul_3_4");
    rd(MFLO, 32'd12, "mul_3_4_lo");
    rd(MFHI, 32'd0, "mul_3_4_hi");

    // DIVU held while MULTU runs: stalled, then accepted in the done cycle
    drive(1'b1, MULTU, 32'd3, 32'd4);
    tick();
    drive(1'b1, DIVU, 32'd50, 32'd6);
    n = 0;
    #2;
    while (stall && n < 100) begin
      n++;
      tick();
      #2;
    end
    chk("divu_held_stall_len", n, 32);
    chk("divu_held_done", {31'b0, done}, 32'h1);
    tick();
    drive(1'b0, NOP, '0, '0);
    chk("divu_held_accepted", {31'b0, busy}, 32'h1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("divu_held_finish", {31'b0, busy}, 32'h0);
    rd(MFLO, 32'd8, "divu_held_q");
    rd(MFHI, 32'd2, "divu_held_r");

    // Random traffic, checked every cycle by the model compare
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
      reset = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb);
      tick();
    end
    reset = 1'b0;
    drive(1'b0, NOP, '0, '0);
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
